// File: rtl/instruction_memory.sv
// Block-read instruction memory with a fixed access latency and a word-wide program-load port.
// A read returns one 16-byte block; the requester is stalled until the block has been captured.
module instruction_memory #(
  parameter int unsigned LATENCY  = 5,
  parameter int unsigned BLOCK_AW = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MEM_READ,
  input  logic [27:0]         MEM_ADDRESS,
  output logic [127:0]        MEM_READDATA,
  output logic                MEM_BUSYWAIT,
  input  logic                LOAD_EN,
  input  logic [BLOCK_AW+1:0] LOAD_ADDR,
  input  logic [31:0]         LOAD_DATA
);

  localparam int unsigned NumWords = 2 ** (BLOCK_AW + 2);
  localparam logic [7:0]  CntLoad  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [BLOCK_AW-1:0] addr_q;
  logic [31:0]         mem_q [NumWords];
  logic [BLOCK_AW-1:0] req_blk;
  logic [127:0]        blk_data;
  logic                unused_addr_hi;

  // Upper address bits alias onto the same storage.
  assign req_blk        = MEM_ADDRESS[BLOCK_AW-1:0];
  assign unused_addr_hi = ^MEM_ADDRESS[27:BLOCK_AW];

  // Storage is never reset so a program loaded before reset survives it.
  always_ff @(posedge CLK) begin
    if (LOAD_EN) begin
      mem_q[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  always_comb begin
    blk_data = '0;
    for (int k = 0; k < 4; k++) begin
      blk_data[32*k +: 32] = mem_q[{addr_q, k[1:0]}];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      MEM_READDATA <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MEM_READ) begin
            addr_q  <= req_blk;
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!MEM_READ) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (req_blk != addr_q) begin
            addr_q <= req_blk;
            cnt_q  <= CntLoad;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            // Nonblocking storage writes land after this read, so a colliding load is not seen.
            MEM_READDATA <= blk_data;
            state_q      <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign MEM_BUSYWAIT = MEM_READ && (state_q != StDone) && !RESET;

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized and directed bench for instruction_memory against a cycle-count reference model.
module tb_instruction_memory;

  localparam int unsigned Lat      = 5;
  localparam int unsigned BlockAw  = 6;
  localparam int          NumBlk   = 1 << BlockAw;
  localparam int          NumWords = NumBlk * 4;

  logic               CLK;
  logic               RESET;
  logic               MEM_READ;
  logic [27:0]        MEM_ADDRESS;
  logic [127:0]       MEM_READDATA;
  logic               MEM_BUSYWAIT;
  logic               LOAD_EN;
  logic [BlockAw+1:0] LOAD_ADDR;
  logic [31:0]        LOAD_DATA;

  instruction_memory #(
    .LATENCY (Lat),
    .BLOCK_AW(BlockAw)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MEM_READ    (MEM_READ),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .LOAD_EN     (LOAD_EN),
    .LOAD_ADDR   (LOAD_ADDR),
    .LOAD_DATA   (LOAD_DATA)
  );

  int total;
  int bad;
  bit chk_en;

  // Reference model: a request is due Lat edges after it was (re)started.
  logic [31:0]  m_mem [NumWords];
  logic [127:0] m_data;
  bit           m_inflight;
  bit           m_done;
  int           m_blk;
  int           m_deadline;
  int           cyc;
  logic [27:0]  ra;
  int           n;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] block_of(input int b);
    return {m_mem[4*b+3], m_mem[4*b+2], m_mem[4*b+1], m_mem[4*b]};
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0;
    m_done     = 1'b0;
    m_data     = '0;
  endtask

  task automatic model_edge();
    int b;
    b = int'(MEM_ADDRESS) % NumBlk;
    cyc++;
    if (RESET) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_inflight) begin
      if (!MEM_READ) begin
        m_inflight = 1'b0;
      end else if (b != m_blk) begin
        m_blk      = b;
        m_deadline = cyc + Lat;
      end else if (cyc == m_deadline) begin
        m_data     = block_of(m_blk);
        m_inflight = 1'b0;
        m_done     = 1'b1;
      end
    end else if (MEM_READ) begin
      m_inflight = 1'b1;
      m_blk      = b;
      m_deadline = cyc + Lat;
    end
    // Loads apply after the capture so a same-edge collision returns the old word.
    if (LOAD_EN) m_mem[int'(LOAD_ADDR)] = LOAD_DATA;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (MEM_BUSYWAIT && cnt < 50);
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("readdata", MEM_READDATA, m_data);
        chk("busywait", 128'(MEM_BUSYWAIT), 128'(MEM_READ && !m_done && !RESET));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    chk_en = 1'b0;
    model_reset();
    RESET       = 1'b1;
    MEM_READ    = 1'b1;
    MEM_ADDRESS = '0;
    LOAD_EN     = 1'b0;
    LOAD_ADDR   = '0;
    LOAD_DATA   = '0;
    #2;
    chk_en = 1'b1;
    chk("reset_data", MEM_READDATA, 128'h0);
    chk("reset_busy", 128'(MEM_BUSYWAIT), 128'h0);

    // Preload while reset is held; storage must survive it.
    for (int i = 0; i < NumWords; i++) begin
      LOAD_EN   = 1'b1;
      LOAD_ADDR = (BlockAw + 2)'(i);
      LOAD_DATA = 32'hC0DE_0000 + 32'(i);
      tick();
    end
    MEM_READ = 1'b0;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      LOAD_ADDR = (BlockAw + 2)'(i);
      LOAD_DATA = 32'h11 * 32'(i + 1);
      tick();
    end
    LOAD_EN = 1'b0;

    // Basic read of block 0.
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'd0;
    #1;
    chk("basic_busy_immediate", 128'(MEM_BUSYWAIT), 128'h1);
    tick();
    wait_done(n);
    chk("basic_latency", 128'(n), 128'd5);
    chk("basic_data", MEM_READDATA, 128'h00000044_00000033_00000022_00000011);
    MEM_READ = 1'b0;
    repeat (3) tick();
    chk("basic_held", MEM_READDATA, 128'h00000044_00000033_00000022_00000011);

    // Abort a block-3 read after two cycles.
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'd3;
    repeat (3) tick();
    MEM_READ = 1'b0;
    tick();
    chk("abort_busy", 128'(MEM_BUSYWAIT), 128'h0);
    chk("abort_data", MEM_READDATA, 128'h00000044_00000033_00000022_00000011);
    MEM_READ = 1'b1;
    tick();
    wait_done(n);
    chk("after_abort_latency", 128'(n), 128'd5);
    chk("after_abort_data", MEM_READDATA, 128'hC0DE000F_C0DE000E_C0DE000D_C0DE000C);
    MEM_READ = 1'b0;
    tick();

    // Restart: address moves from block 1 to block 2 mid-wait.
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'd1;
    repeat (3) tick();
    MEM_ADDRESS = 28'd2;
    tick();
    wait_done(n);
    chk("restart_latency", 128'(n), 128'd5);
    chk("restart_data", MEM_READDATA, 128'hC0DE000B_C0DE000A_C0DE0009_C0DE0008);
    MEM_READ = 1'b0;
    tick();

    // Back-to-back: DONE, one IDLE cycle, then a full latency.
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'd0;
    tick();
    wait_done(n);
    wait_done(n);
    chk("b2b_gap", 128'(n), 128'(Lat + 2));
    chk("b2b_data", MEM_READDATA, 128'h00000044_00000033_00000022_00000011);
    MEM_READ = 1'b0;
    tick();

    // Load to word 8 on the capture edge of a block-2 read.
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'd2;
    repeat (5) tick();
    LOAD_EN   = 1'b1;
    LOAD_ADDR = (BlockAw + 2)'(8);
    LOAD_DATA = 32'hDEAD_BEEF;
    tick();
    LOAD_EN = 1'b0;
    chk("collide_busy", 128'(MEM_BUSYWAIT), 128'h0);
    chk("collide_old", MEM_READDATA, 128'hC0DE000B_C0DE000A_C0DE0009_C0DE0008);
    MEM_READ = 1'b0;
    tick();
    MEM_READ = 1'b1;
    tick();
    wait_done(n);
    chk("collide_new", MEM_READDATA, 128'hC0DE000B_C0DE000A_C0DE0009_DEADBEEF);
    MEM_READ = 1'b0;
    tick();

    // Reset pulse mid-wait, then a fresh read of block 0.
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'd0;
    repeat (3) tick();
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_data", MEM_READDATA, 128'h0);
    chk("rst_mid_busy", 128'(MEM_BUSYWAIT), 128'h0);
    repeat (2) tick();
    chk("rst_hold_busy", 128'(MEM_BUSYWAIT), 128'h0);
    RESET = 1'b0;
    tick();
    wait_done(n);
    chk("rst_after_latency", 128'(n), 128'd5);
    chk("rst_after_data", MEM_READDATA, 128'h00000044_00000033_00000022_00000011);

    // Random traffic with aliased addresses, stray loads and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) MEM_READ = ~MEM_READ;
      if ($urandom_range(0, 15) == 0) begin
        ra = 28'($urandom);
        if ($urandom_range(0, 1) == 1) ra[BlockAw-1:0] = BlockAw'($urandom_range(0, 3));
        MEM_ADDRESS = ra;
      end
      LOAD_EN   = ($urandom_range(0, 3) == 0);
      LOAD_ADDR = ($urandom_range(0, 1) == 1) ? (BlockAw + 2)'($urandom_range(0, 15))
                                              : (BlockAw + 2)'($urandom);
      LOAD_DATA = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        RESET = 1'b1;
        model_reset();
      end else begin
        RESET = 1'b0;
      end
      tick();
    end
    RESET    = 1'b0;
    MEM_READ = 1'b0;
    LOAD_EN  = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
